// File: rtl/oled_ssd1351_pkg.sv
// Shared opcodes, decoder states and default geometry for the SSD1351 receive model.
package oled_ssd1351_pkg;

  localparam logic [7:0] C_CMD_SET_COL   = 8'h15;
  localparam logic [7:0] C_CMD_SET_ROW   = 8'h75;
  localparam logic [7:0] C_CMD_WRITE_RAM = 8'h5C;

  localparam int C_DEF_X_SIZE     = 128;
  localparam int C_DEF_Y_SIZE     = 128;
  localparam int C_DEF_COLOR_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_COL_ARG0,
    S_COL_ARG1,
    S_ROW_ARG0,
    S_ROW_ARG1,
    S_WRITE
  } state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } spi_byte_t;

endpackage

// File: rtl/oled_spi_deser.sv
// Oversampling SPI byte receiver: 2-FF synchronisers, spi_clk rise detect, MSB-first shifter.
module oled_spi_deser
  import oled_ssd1351_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      spi_csn_i,
  input  logic      spi_clk_i,
  input  logic      spi_mosi_i,
  input  logic      spi_dc_i,
  input  logic      spi_resn_i,
  output logic      resn_o,
  output logic      byte_strobe_o,
  output spi_byte_t byte_o
);

  // Bit order in the synchroniser vectors: {resn, dc, mosi, sclk, csn}
  localparam logic [4:0] C_SYNC_RST = 5'b10001;

  logic [4:0] meta_q, sync_q;
  logic       sclk_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       strobe_q, strobe_d;
  spi_byte_t  byte_q, byte_d;

  logic csn_s, sclk_s, mosi_s, dc_s, resn_s, sclk_rise;

  assign csn_s     = sync_q[0];
  assign sclk_s    = sync_q[1];
  assign mosi_s    = sync_q[2];
  assign dc_s      = sync_q[3];
  assign resn_s    = sync_q[4];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    byte_d   = byte_q;
    if (!resn_s || csn_s) begin
      cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d = {shift_q[6:0], mosi_s};
      if (cnt_q == 3'd7) begin
        strobe_d = 1'b1;
        byte_d   = {dc_s, shift_d};
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q      <= C_SYNC_RST;
      sync_q      <= C_SYNC_RST;
      sclk_prev_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      strobe_q    <= 1'b0;
      byte_q      <= '0;
    end else begin
      meta_q      <= {spi_resn_i, spi_dc_i, spi_mosi_i, spi_clk_i, spi_csn_i};
      sync_q      <= meta_q;
      sclk_prev_q <= sclk_s;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      strobe_q    <= strobe_d;
      byte_q      <= byte_d;
    end
  end

  assign resn_o        = resn_s;
  assign byte_strobe_o = strobe_q;
  assign byte_o        = byte_q;

endmodule

// File: rtl/oled_ssd1351_sink.sv
// SSD1351 SPI sink: decodes column/row window and write-RAM commands into a pixel stream.
module oled_ssd1351_sink
  import oled_ssd1351_pkg::*;
#(
  parameter int c_x_size     = C_DEF_X_SIZE,
  parameter int c_y_size     = C_DEF_Y_SIZE,
  parameter int c_color_bits = C_DEF_COLOR_BITS,
  localparam int XW = $clog2(c_x_size),
  localparam int YW = $clog2(c_y_size)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          spi_csn_i,
  input  logic          spi_clk_i,
  input  logic          spi_mosi_i,
  input  logic          spi_dc_i,
  input  logic          spi_resn_i,
  output logic          pixel_valid_o,
  output logic [XW-1:0] pixel_x_o,
  output logic [YW-1:0] pixel_y_o,
  output logic [15:0]   pixel_color_o,
  output logic          cmd_valid_o,
  output logic [7:0]    cmd_byte_o,
  output logic          frame_done_o
);

  localparam logic [XW-1:0] C_COL_END = XW'(c_x_size - 1);
  localparam logic [YW-1:0] C_ROW_END = YW'(c_y_size - 1);

  logic      resn_s, rx_strobe;
  spi_byte_t rx;

  oled_spi_deser u_deser (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .spi_csn_i    (spi_csn_i),
    .spi_clk_i    (spi_clk_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_dc_i     (spi_dc_i),
    .spi_resn_i   (spi_resn_i),
    .resn_o       (resn_s),
    .byte_strobe_o(rx_strobe),
    .byte_o       (rx)
  );

  state_e        state_q, state_d;
  logic [XW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, x_q, x_d;
  logic [YW-1:0] row_start_q, row_start_d, row_end_q, row_end_d, y_q, y_d;
  logic [7:0]    hi_q, hi_d;
  logic          half_q, half_d;

  logic          pv_q, pv_d, cv_q, cv_d, fd_q, fd_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic [15:0]   pc_q, pc_d;
  logic [7:0]    cb_q, cb_d;

  always_comb begin
    state_d     = state_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    half_d      = half_q;
    pv_d        = 1'b0;
    cv_d        = 1'b0;
    fd_d        = 1'b0;
    px_d        = px_q;
    py_d        = py_q;
    pc_d        = pc_q;
    cb_d        = cb_q;
    if (rx_strobe) begin
      if (!rx.dc) begin
        // Any command drops a half-received pixel or pending argument.
        cv_d   = 1'b1;
        cb_d   = rx.data;
        half_d = 1'b0;
        case (rx.data)
          C_CMD_SET_COL:   state_d = S_COL_ARG0;
          C_CMD_SET_ROW:   state_d = S_ROW_ARG0;
          C_CMD_WRITE_RAM: begin
            state_d = S_WRITE;
            x_d     = col_start_q;
            y_d     = row_start_q;
          end
          default:         state_d = S_SKIP;
        endcase
      end else begin
        case (state_q)
          S_COL_ARG0: begin col_start_d = XW'(rx.data); state_d = S_COL_ARG1; end
          S_COL_ARG1: begin col_end_d   = XW'(rx.data); state_d = S_IDLE;     end
          S_ROW_ARG0: begin row_start_d = YW'(rx.data); state_d = S_ROW_ARG1; end
          S_ROW_ARG1: begin row_end_d   = YW'(rx.data); state_d = S_IDLE;     end
          S_WRITE: begin
            if (c_color_bits == 16 && !half_q) begin
              hi_d   = rx.data;
              half_d = 1'b1;
            end else begin
              pv_d   = 1'b1;
              px_d   = x_q;
              py_d   = y_q;
              pc_d   = (c_color_bits == 16) ? {hi_q, rx.data} : {8'h00, rx.data};
              half_d = 1'b0;
              if (x_q == col_end_q) begin
                x_d = col_start_q;
                if (y_q == row_end_q) begin
                  y_d  = row_start_q;
                  fd_d = 1'b1;
                end else begin
                  y_d = YW'(y_q + 1'b1);
                end
              end else begin
                x_d = XW'(x_q + 1'b1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Display reset behaves like block reset, but only once it is synchronised.
  always_ff @(posedge clk_i) begin
    if (reset_i || !resn_s) begin
      state_q     <= S_IDLE;
      col_start_q <= '0;
      col_end_q   <= C_COL_END;
      row_start_q <= '0;
      row_end_q   <= C_ROW_END;
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      half_q      <= 1'b0;
      pv_q        <= 1'b0;
      cv_q        <= 1'b0;
      fd_q        <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      pc_q        <= '0;
      cb_q        <= '0;
    end else begin
      state_q     <= state_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      half_q      <= half_d;
      pv_q        <= pv_d;
      cv_q        <= cv_d;
      fd_q        <= fd_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pc_q        <= pc_d;
      cb_q        <= cb_d;
    end
  end

  assign pixel_valid_o = pv_q;
  assign pixel_x_o     = px_q;
  assign pixel_y_o     = py_q;
  assign pixel_color_o = pc_q;
  assign cmd_valid_o   = cv_q;
  assign cmd_byte_o    = cb_q;
  assign frame_done_o  = fd_q;

endmodule

// File: tb/tb_oled_ssd1351_sink.sv
// Bench for oled_ssd1351_sink: a 128x128 16-bit instance and an 8x8 8-bit instance on one SPI bus.
module tb_oled_ssd1351_sink;

  logic clk = 1'b0, reset = 1'b1;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, spi_resn = 1'b1;
  logic csn_a = 1'b1, csn_b = 1'b1;
  logic tgt = 1'b0;

  logic        pv_a, cv_a, fd_a;
  logic [6:0]  px_a, py_a;
  logic [15:0] pc_a;
  logic [7:0]  cb_a;
  logic        pv_b, cv_b, fd_b;
  logic [2:0]  px_b, py_b;
  logic [15:0] pc_b;
  logic [7:0]  cb_b;

  always #5 clk = ~clk;

  oled_ssd1351_sink u_dut_a (
    .clk_i(clk), .reset_i(reset), .spi_csn_i(csn_a), .spi_clk_i(spi_clk),
    .spi_mosi_i(spi_mosi), .spi_dc_i(spi_dc), .spi_resn_i(spi_resn),
    .pixel_valid_o(pv_a), .pixel_x_o(px_a), .pixel_y_o(py_a), .pixel_color_o(pc_a),
    .cmd_valid_o(cv_a), .cmd_byte_o(cb_a), .frame_done_o(fd_a)
  );

  oled_ssd1351_sink #(.c_x_size(8), .c_y_size(8), .c_color_bits(8)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .spi_csn_i(csn_b), .spi_clk_i(spi_clk),
    .spi_mosi_i(spi_mosi), .spi_dc_i(spi_dc), .spi_resn_i(spi_resn),
    .pixel_valid_o(pv_b), .pixel_x_o(px_b), .pixel_y_o(py_b), .pixel_color_o(pc_b),
    .cmd_valid_o(cv_b), .cmd_byte_o(cb_b), .frame_done_o(fd_b)
  );

  typedef struct packed {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [15:0] c;
    logic        fd;
  } pix_t;

  typedef struct {
    logic        dc;
    logic [7:0]  d;
    logic        pix;
    pix_t        exp;
  } vec_t;

  pix_t       q_a[$], q_b[$];
  logic [7:0] qc_a[$];
  pix_t       ea, eb;
  logic [7:0] ec;
  int checks = 0, failures = 0;
  int cyc = 0, rise_cyc = 0, pix_b_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare whenever a DUT strobes an output.
  always @(negedge clk) begin
    if (!reset) begin
      if (pv_a) begin
        checks++;
        if (q_a.size() == 0) begin
          failures++;
          $display("FAIL pix_a_unexpected got x=%0d y=%0d c=%h fd=%b", px_a, py_a, pc_a, fd_a);
        end else begin
          ea = q_a.pop_front();
          if ({px_a, py_a, pc_a, fd_a} !== ea) begin
            failures++;
            $display("FAIL pix_a got x=%0d y=%0d c=%h fd=%b exp x=%0d y=%0d c=%h fd=%b",
                     px_a, py_a, pc_a, fd_a, ea.x, ea.y, ea.c, ea.fd);
          end
        end
      end else if (fd_a) begin
        checks++; failures++;
        $display("FAIL fd_a_alone got=1 exp=0");
      end
      if (pv_b) begin
        pix_b_cyc = cyc;
        checks++;
        if (q_b.size() == 0) begin
          failures++;
          $display("FAIL pix_b_unexpected got x=%0d y=%0d c=%h fd=%b", px_b, py_b, pc_b, fd_b);
        end else begin
          eb = q_b.pop_front();
          if ({4'b0, px_b, 4'b0, py_b, pc_b, fd_b} !== eb) begin
            failures++;
            $display("FAIL pix_b got x=%0d y=%0d c=%h fd=%b exp x=%0d y=%0d c=%h fd=%b",
                     px_b, py_b, pc_b, fd_b, eb.x, eb.y, eb.c, eb.fd);
          end
        end
      end else if (fd_b) begin
        checks++; failures++;
        $display("FAIL fd_b_alone got=1 exp=0");
      end
      if (cv_a) begin
        checks++;
        if (qc_a.size() == 0) begin
          failures++;
          $display("FAIL cmd_a_unexpected got=%h", cb_a);
        end else begin
          ec = qc_a.pop_front();
          if (cb_a !== ec) begin
            failures++;
            $display("FAIL cmd_a got=%h exp=%h", cb_a, ec);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // SPI mode 0 at clk/4: mosi set with spi_clk low, sampled two clk later on the rise.
  task automatic send_bits(input logic dc, input logic [7:0] d, input int n);
    @(negedge clk);
    csn_a = tgt; csn_b = ~tgt; spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[7-i]; spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      spi_clk = 1'b1; rise_cyc = cyc;
      repeat (2) @(negedge clk);
    end
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] d);
    send_bits(dc, d, 8);
  endtask

  task automatic cmd(input logic [7:0] b);
    if (!tgt) qc_a.push_back(b);
    send_byte(1'b0, b);
  endtask

  task automatic exp_pix(input int x, input int y, input logic [15:0] c, input logic fd);
    pix_t p;
    p = '{x: 7'(x), y: 7'(y), c: c, fd: fd};
    if (tgt) q_b.push_back(p); else q_a.push_back(p);
  endtask

  task automatic pix16(input logic [15:0] c);
    send_byte(1'b1, c[15:8]);
    send_byte(1'b1, c[7:0]);
  endtask

  task automatic drain(input string name);
    repeat (8) @(negedge clk);
    check({name, "_drained"}, 64'(q_a.size() + q_b.size() + qc_a.size()), 64'd0);
  endtask

  function automatic vec_t mk(input logic dc, input logic [7:0] d, input logic pix,
                              input int x, input int y, input logic [15:0] c, input logic fd);
    vec_t v;
    v.dc = dc; v.d = d; v.pix = pix;
    v.exp = '{x: 7'(x), y: 7'(y), c: c, fd: fd};
    return v;
  endfunction

  vec_t tv[31];

  initial begin
    // Column window 2..5, row window 16..17, then 12 pixels spanning 1.5 frames.
    tv[0] = mk(1'b0, 8'h15, 1'b0, 0, 0, 16'h0, 1'b0);
    tv[1] = mk(1'b1, 8'h02, 1'b0, 0, 0, 16'h0, 1'b0);
    tv[2] = mk(1'b1, 8'h05, 1'b0, 0, 0, 16'h0, 1'b0);
    tv[3] = mk(1'b0, 8'h75, 1'b0, 0, 0, 16'h0, 1'b0);
    tv[4] = mk(1'b1, 8'h10, 1'b0, 0, 0, 16'h0, 1'b0);
    tv[5] = mk(1'b1, 8'h11, 1'b0, 0, 0, 16'h0, 1'b0);
    tv[6] = mk(1'b0, 8'h5C, 1'b0, 0, 0, 16'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tv[7+2*i] = mk(1'b1, 8'h00, 1'b0, 0, 0, 16'h0, 1'b0);
      tv[8+2*i] = mk(1'b1, 8'(i), 1'b1, 2 + i % 4, 16 + (i / 4) % 2, 16'(i), i == 7);
    end

    repeat (4) @(negedge clk);
    check("reset_a", {pv_a, cv_a, fd_a, px_a, py_a, pc_a, cb_a}, 64'd0);
    check("reset_b", {pv_b, cv_b, fd_b, px_b, py_b, pc_b, cb_b}, 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    tgt = 1'b0;
    foreach (tv[k]) begin
      if (!tv[k].dc) qc_a.push_back(tv[k].d);
      if (tv[k].pix) q_a.push_back(tv[k].exp);
      send_byte(tv[k].dc, tv[k].d);
    end
    drain("window");

    // Partial byte dropped on csn high; 0xAB then pairs with 0xCD.
    send_bits(1'b1, 8'hFF, 5);
    @(negedge clk); csn_a = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(1'b1, 8'hAB);
    drain("partial");
    exp_pix(2, 17, 16'hABCD, 1'b0);
    send_byte(1'b1, 8'hCD);
    drain("partial_pix");

    // Command mid-pixel aborts; unknown opcode parks the decoder in SKIP.
    send_byte(1'b1, 8'h12);
    cmd(8'hAF);
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    drain("skip");
    cmd(8'h5C);
    exp_pix(2, 16, 16'h5678, 1'b0);
    pix16(16'h5678);
    drain("rewrite");

    // Bottom-right corner window: frame end at (127,127) then wrap to window start.
    cmd(8'h15); send_byte(1'b1, 8'd126); send_byte(1'b1, 8'd127);
    cmd(8'h75); send_byte(1'b1, 8'd126); send_byte(1'b1, 8'd127);
    cmd(8'h5C);
    for (int i = 0; i < 5; i++) begin
      exp_pix(126 + i % 2, 126 + (i / 2) % 2, 16'h1000 + 16'(i), i == 3);
      pix16(16'h1000 + 16'(i));
    end
    drain("corner");

    // Display reset mid-window restores the default full-screen window.
    send_byte(1'b1, 8'h77);
    @(negedge clk); csn_a = 1'b1; spi_resn = 1'b0;
    repeat (6) @(negedge clk);
    spi_resn = 1'b1;
    repeat (6) @(negedge clk);
    check("resn_outputs_a", {pv_a, cv_a, fd_a, px_a, py_a, pc_a, cb_a}, 64'd0);
    cmd(8'h5C);
    exp_pix(0, 0, 16'h1234, 1'b0);
    pix16(16'h1234);
    drain("resn");

    // 8-bit instance: full default window, frame end, wrap to origin.
    tgt = 1'b1;
    send_byte(1'b0, 8'h5C);
    for (int i = 0; i < 65; i++) begin
      exp_pix(i % 8, (i / 8) % 8, 16'(i + 8'h40) & 16'h00FF, i == 63);
      send_byte(1'b1, 8'(i + 8'h40));
    end
    drain("frame_b");

    // Pixel out one clk after the byte strobe, i.e. a few clk after the last sampling edge.
    pix_b_cyc = -1;
    exp_pix(1, 0, 16'h003C, 1'b0);
    send_byte(1'b1, 8'h3C);
    repeat (6) @(negedge clk);
    check("latency_b_in_range",
          64'((pix_b_cyc - rise_cyc) >= 3 && (pix_b_cyc - rise_cyc) <= 5), 64'd1);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_ssd1351_sink.md
Name: oled_ssd1351_sink

Overview:
- Receive-side model of the SSD1351 4-wire SPI link that oled_video drives.
- Oversamples spi_csn/spi_clk/spi_mosi/spi_dc/spi_resn.
- Deserialises bytes and decodes the column-window, row-window and write-RAM commands into a pixel-write stream (x, y, color).
- Serves as the bench scoreboard for oled_video and as the front end for mirroring the OLED image into a framebuffer.

Parameters:
- c_x_size, 128: columns; pixel_x width = clog2(c_x_size).
- c_y_size, 128: rows; pixel_y width = clog2(c_y_size).
- c_color_bits, 16: 16 = two data bytes per pixel, high byte first; 8 = one byte per pixel, zero-extended into the low byte.

Ports:
- clk, in, 1: single clock, must be at least 4x the spi_clk frequency.
- reset, in, 1: synchronous, active-high.
- spi_csn, in, 1: chip select, active low.
- spi_clk, in, 1: SPI clock; data is sampled on its rising edge (mode 0/3).
- spi_mosi, in, 1: serial data, MSB first.
- spi_dc, in, 1: 0 = command byte, 1 = data byte; sampled with the 8th bit.
- spi_resn, in, 1: display reset, active low.
- pixel_valid, out, 1: one-cycle strobe per completed pixel.
- pixel_x, out, clog2(c_x_size): column of the written pixel.
- pixel_y, out, clog2(c_y_size): row of the written pixel.
- pixel_color, out, 16: pixel value.
- cmd_valid, out, 1: one-cycle strobe for every command byte.
- cmd_byte, out, 8: opcode accompanying cmd_valid.
- frame_done, out, 1: one-cycle strobe, coincident with the pixel_valid of the last pixel in the window.

Behaviour:
- Reset values: all outputs 0; window col = 0..c_x_size-1, row = 0..c_y_size-1; cursor (0,0); FSM = IDLE; bit count 0.
- Input capture: every input passes through a 2-FF synchroniser. A rise on the synchronised spi_clk while synchronised csn = 0 shifts mosi into an 8-bit shift register.
- Byte completion: on the 8th bit, byte_strobe fires with {dc, byte}.
- Framing aborts: csn high clears the bit count, so a partial byte is discarded; FSM state is kept across csn toggles.
- spi_resn low (synchronised): acts as reset for the window, cursor, FSM and bit count; outputs go to 0.
- Latency: pixel_valid, cmd_valid and frame_done are registered exactly 1 clk after the byte_strobe that completes them.
- Command bytes (dc = 0):
  - Always emit cmd_valid/cmd_byte and abort any partial pixel or argument.
  - 0x15 -> COL_ARG0.
  - 0x75 -> ROW_ARG0.
  - 0x5C -> WRITE; cursor reset to (col_start, row_start); half-pixel flag cleared.
  - Any other opcode -> SKIP.
- FSM states and transitions:
  - IDLE / SKIP: data bytes ignored.
  - COL_ARG0 -> store col_start -> COL_ARG1 -> store col_end -> IDLE.
  - ROW_ARG0 -> ROW_ARG1 -> IDLE, same pattern for row_start/row_end.
  - WRITE: data bytes form pixels. In 16-bit mode the first byte is held as the high byte and the second completes the pixel.
- Argument width: arguments are truncated to the coordinate width.
- Inverted window: start > end is stored unchanged; the cursor wraps when x == col_end, so the bench must not rely on inverted-window behaviour.
- Cursor advance after each pixel:
  - If x == col_end: x <= col_start, and y advances.
  - If y == row_end on that wrap: y <= row_start and frame_done pulses.
  - Otherwise x <= x+1.
- WRITE persistence: writes continue indefinitely until the next command byte.
- Simultaneous events: reset dominates spi_resn, which dominates byte_strobe.

Decomposition:
- Package oled_ssd1351_pkg: opcode constants (C_CMD_SET_COL = 8'h15, C_CMD_SET_ROW = 8'h75, C_CMD_WRITE_RAM = 8'h5C), FSM state enum, and default window constants.
- Sub-module oled_spi_deser: synchroniser, edge detect, 8-bit shifter and bit counter. Outputs byte_strobe, byte_data and byte_dc.
- Top module: decoder FSM plus cursor logic.

Test Plan:
- Reset, then 0x15 / 0x02 / 0x05 (col window), 0x75 / 0x10 / 0x11 (row window), 0x5C, then 12 pixels 0x0000..0x000B -> pixel_valid x12 at (2,16)..(5,16),(2,17)..(5,17),(2,16)..(5,16) with matching colors; frame_done on the 8th pixel, (5,17).
- After reset, 0x5C plus 128*128 pixels of color 0xF800 -> 16384 pixel_valid strobes; last pixel at (127,127) with frame_done; the next pixel lands at (0,0).
- csn raised after 5 bits of a data byte, then a full byte 0xAB -> partial byte discarded; 0xAB is taken as a high byte and no pixel is emitted until the next byte.
- In WRITE, one data byte 0x12, then command 0xAF -> no pixel; cmd_valid with cmd_byte = 0xAF; FSM in SKIP, so later data bytes produce no pixels.
- spi_resn pulsed low mid-window, then 0x5C plus one pixel 0x1234 -> pixel at (0,0), confirming the window reverted to the defaults.
- c_color_bits = 8: 0x5C, then 0x3C -> pixel_color = 0x003C one clk after the byte strobe.
